// File: rtl/vga_scan_ctrl.sv
// VGA scan sequencer: per-axis porch/sync FSMs, registered sync/de/coordinates, line-fetch req/ack with underrun flag.
// Optional colour-bar generator (R/G/B outputs) when VGA_TEST_PATTERN_EN is defined.
module vga_scan_ctrl #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic       vga_h_sync,
  output logic       vga_v_sync,
  output logic       de,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       frame_start,
  output logic       line_req,
  output logic [9:0] line_y,
  input  logic       line_ack,
  output logic       underrun
`ifdef VGA_TEST_PATTERN_EN
  ,
  output logic       R,
  output logic       G,
  output logic       B
`endif
);

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  localparam int H_MAX = max4(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_MAX = max4(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW    = (H_MAX > 1) ? $clog2(H_MAX) : 1;
  localparam int VW    = (V_MAX > 1) ? $clog2(V_MAX) : 1;

  typedef logic [HW-1:0] hcnt_t;
  typedef logic [VW-1:0] vcnt_t;
  typedef enum logic [1:0] {ST_H_ACT, ST_H_FP, ST_H_SYNC, ST_H_BP} h_state_t;
  typedef enum logic [1:0] {ST_V_ACT, ST_V_FP, ST_V_SYNC, ST_V_BP} v_state_t;

  h_state_t r_h_state, w_h_next;
  v_state_t r_v_state, w_v_next;
  hcnt_t    r_hcnt, w_h_last;
  vcnt_t    r_vcnt, w_v_last;
  logic     w_h_done, w_v_done, w_line_adv, w_visible, w_h_start;
  logic     w_next_vis, w_launch;
  logic [9:0] w_next_y;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_h_last = hcnt_t'(H_ACTIVE - 1);
    w_h_next = ST_H_FP;
    case (r_h_state)
      ST_H_ACT:  begin w_h_last = hcnt_t'(H_ACTIVE - 1); w_h_next = ST_H_FP;   end
      ST_H_FP:   begin w_h_last = hcnt_t'(H_FP - 1);     w_h_next = ST_H_SYNC; end
      ST_H_SYNC: begin w_h_last = hcnt_t'(H_SYNC - 1);   w_h_next = ST_H_BP;   end
      ST_H_BP:   begin w_h_last = hcnt_t'(H_BP - 1);     w_h_next = ST_H_ACT;  end
      default:   ;
    endcase
  end

  always_comb begin
    w_v_last = vcnt_t'(V_ACTIVE - 1);
    w_v_next = ST_V_FP;
    case (r_v_state)
      ST_V_ACT:  begin w_v_last = vcnt_t'(V_ACTIVE - 1); w_v_next = ST_V_FP;   end
      ST_V_FP:   begin w_v_last = vcnt_t'(V_FP - 1);     w_v_next = ST_V_SYNC; end
      ST_V_SYNC: begin w_v_last = vcnt_t'(V_SYNC - 1);   w_v_next = ST_V_BP;   end
      ST_V_BP:   begin w_v_last = vcnt_t'(V_BP - 1);     w_v_next = ST_V_ACT;  end
      default:   ;
    endcase
  end

  assign w_h_done   = (r_hcnt == w_h_last);
  assign w_v_done   = (r_vcnt == w_v_last);
  assign w_line_adv = (r_h_state == ST_H_BP) && w_h_done;
  assign w_visible  = (r_h_state == ST_H_ACT) && (r_v_state == ST_V_ACT);
  assign w_h_start  = (r_h_state == ST_H_ACT) && (r_hcnt == '0);

  // The line after this blanking interval is visible either mid-frame or from the last back-porch line.
  always_comb begin
    w_next_vis = 1'b0;
    w_next_y   = '0;
    if (r_v_state == ST_V_ACT && !w_v_done) begin
      w_next_vis = 1'b1;
      w_next_y   = 10'(r_vcnt) + 10'd1;
    end else if (r_v_state == ST_V_BP && w_v_done) begin
      w_next_vis = 1'b1;
    end
  end

  assign w_launch = (r_h_state == ST_H_FP) && (r_hcnt == '0) && w_next_vis;

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h_state   <= ST_H_FP;
      r_hcnt      <= '0;
      r_v_state   <= ST_V_BP;
      r_vcnt      <= vcnt_t'(V_BP - 1);
      vga_h_sync  <= ~SYNC_POL;
      vga_v_sync  <= ~SYNC_POL;
      de          <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      line_req    <= 1'b0;
      line_y      <= '0;
      underrun    <= 1'b0;
    end else begin
      vga_h_sync  <= (enable && r_h_state == ST_H_SYNC) ? SYNC_POL : ~SYNC_POL;
      vga_v_sync  <= (enable && r_v_state == ST_V_SYNC) ? SYNC_POL : ~SYNC_POL;
      de          <= enable && w_visible;
      frame_start <= enable && w_visible && w_h_start && (r_vcnt == '0);
      if (enable && w_visible) begin
        pix_x <= 10'(r_hcnt);
        pix_y <= 10'(r_vcnt);
      end
      if (enable) begin
        if (w_h_done) begin
          r_hcnt    <= '0;
          r_h_state <= w_h_next;
        end else begin
          r_hcnt <= r_hcnt + 1'b1;
        end
        if (w_line_adv) begin
          if (w_v_done) begin
            r_vcnt    <= '0;
            r_v_state <= w_v_next;
          end else begin
            r_vcnt <= r_vcnt + 1'b1;
          end
        end
        // Deadline is the first active clk of the line; an ack arriving in that clk is still on time.
        if (w_launch) begin
          line_req <= 1'b1;
          line_y   <= w_next_y;
        end else if (line_req && w_h_start) begin
          line_req <= 1'b0;
          if (!line_ack) underrun <= 1'b1;
        end else if (line_req && line_ack) begin
          line_req <= 1'b0;
        end
      end
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  logic [BW-1:0] r_bar_cnt;
  logic [2:0]    r_bar;

  // Bar index tracks the current pixel by counting BAR_W clks per bar, cleared outside the active span.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bar_cnt <= '0;
      r_bar     <= '0;
      R         <= 1'b0;
      G         <= 1'b0;
      B         <= 1'b0;
    end else begin
      {R, G, B} <= (enable && w_visible) ? r_bar : 3'b000;
      if (enable) begin
        if (r_h_state != ST_H_ACT) begin
          r_bar_cnt <= '0;
          r_bar     <= '0;
        end else if (r_bar_cnt == BW'(BAR_W - 1)) begin
          r_bar_cnt <= '0;
          r_bar     <= r_bar + 3'd1;
        end else begin
          r_bar_cnt <= r_bar_cnt + 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Directed bench for vga_scan_ctrl on a reduced raster (356-clk lines, 19-line frames) with a bench-driven ack responder.
// RGB checks apply when VGA_TEST_PATTERN_EN is defined.
module tb_vga_scan_ctrl;
  localparam int HA = 320, HF = 8, HS = 16, HB = 12;
  localparam int VA = 12,  VF = 2, VS = 2,  VB = 3;
  localparam int HT    = HA + HF + HS + HB;        // 356 clks per line
  localparam int BLANK = HF + HS + HB;             // 36 clks from reset to first active state
  localparam int FR    = HT * (VA + VF + VS + VB); // 6764 clks per frame
  localparam int T0    = BLANK + 1;                // clk on which de is first seen high

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       line_ack = 1'b0;
  logic       vga_h_sync, vga_v_sync, de, frame_start, line_req, underrun;
  logic [9:0] pix_x, pix_y, line_y;
`ifdef VGA_TEST_PATTERN_EN
  logic       R, G, B;
`endif

  vga_scan_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .vga_h_sync (vga_h_sync),
    .vga_v_sync (vga_v_sync),
    .de         (de),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .frame_start(frame_start),
    .line_req   (line_req),
    .line_y     (line_y),
    .line_ack   (line_ack),
    .underrun   (underrun)
`ifdef VGA_TEST_PATTERN_EN
    ,
    .R          (R),
    .G          (G),
    .B          (B)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int age = 0;
  bit acked = 1'b0;
  int no_ack_y = 1023;
  int edge_ack_y = 1023;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clk; outputs are sampled 1ns after the edge and the ack responder updates line_ack.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    line_ack = 1'b0;
    if (line_req === 1'b1 && !acked) begin
      age++;
      if (int'(line_y) != no_ack_y &&
          age == ((int'(line_y) == edge_ack_y) ? BLANK : 3)) begin
        line_ack = 1'b1;
        acked    = 1'b1;
      end
    end
    if (line_req !== 1'b1) begin
      age   = 0;
      acked = 1'b0;
    end
  endtask

  task automatic tick_to(input int n);
    while (cyc < n) tick();
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return de;
      1:       return vga_h_sync;
      default: return vga_v_sync;
    endcase
  endfunction

  task automatic wait_sig(input int which, input logic val, input int budget, input string tag);
    int n;
    n = 0;
    while (sig(which) !== val && n < budget) begin
      tick();
      n++;
    end
    if (sig(which) !== val) check(tag, 32'(sig(which)), 32'(val));
  endtask

  initial begin
    int t;
    int bad;
    int n;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_hsync", vga_h_sync, 1);
    check("rst_vsync", vga_v_sync, 1);
    check("rst_de", de, 0);
    check("rst_req", line_req, 0);
    check("rst_underrun", underrun, 0);
    check("rst_fs", frame_start, 0);

    // First line request and its ack after 3 clks
    rst = 1'b0;
    enable = 1'b1;
    cyc = 0;
    tick();
    check("first_req", line_req, 1);
    check("first_req_y", line_y, 0);
    tick_to(3);
    check("req_held", line_req, 1);
    tick();
    check("req_dropped", line_req, 0);

    // First visible pixel and line timing
    tick_to(T0 - 1);
    check("de_before", de, 0);
    tick();
    check("de_first", de, 1);
    check("fs_first", frame_start, 1);
    check("fs_x", pix_x, 0);
    check("fs_y", pix_y, 0);
    tick();
    check("fs_one_clk", frame_start, 0);
    check("pix_x1", pix_x, 1);
    wait_sig(0, 1'b0, HA + 10, "de_fall_timeout");
    check("de_width", cyc - T0, HA);
    check("req_line1", line_req, 1);
    check("req_line1_y", line_y, 1);
    wait_sig(1, 1'b0, HT, "hs_fall_timeout");
    check("hs_start", cyc - T0, HA + HF);
    t = cyc;
    wait_sig(1, 1'b1, HT, "hs_rise_timeout");
    check("hs_width", cyc - t, HS);
    wait_sig(0, 1'b1, HT, "de_rise_timeout");
    check("line_period", cyc - T0, HT);
    check("line1_y", pix_y, 1);

    // Ack exactly on the deadline clk of line 3, then a spurious ack
    edge_ack_y = 3;
    tick_to(T0 + 3 * HT - 1);
    check("edge_req", line_req, 1);
    check("edge_req_y", line_y, 3);
    tick();
    check("edge_de", de, 1);
    check("edge_y", pix_y, 3);
    check("edge_req_drop", line_req, 0);
    check("edge_no_underrun", underrun, 0);
    edge_ack_y = 1023;
    tick_to(T0 + 3 * HT + 100);
    line_ack = 1'b1;
    tick();
    tick();
    check("spur_req", line_req, 0);
    check("spur_underrun", underrun, 0);
    tick_to(T0 + 3 * HT + HA);
    check("req_line4", line_req, 1);
    check("req_line4_y", line_y, 4);

    // Line 5 is never acknowledged
    no_ack_y = 5;
    tick_to(T0 + 5 * HT - 1);
    check("late_req", line_req, 1);
    check("late_pre_underrun", underrun, 0);
    tick();
    check("late_de", de, 1);
    check("late_y", pix_y, 5);
    check("late_underrun", underrun, 1);
    check("late_req_drop", line_req, 0);
    no_ack_y = 1023;
    tick_to(T0 + 5 * HT + HA);
    check("req_line6_y", line_y, 6);

    // Vertical sync spans lines 14..15 of the 19-line frame
    tick_to(T0 + 14 * HT - 1);
    check("vs_before", vga_v_sync, 1);
    tick();
    check("vs_start", vga_v_sync, 0);
    tick_to(T0 + 16 * HT - 1);
    check("vs_last", vga_v_sync, 0);
    tick();
    check("vs_end", vga_v_sync, 1);

    // Second frame
    tick_to(T0 + FR);
    check("f1_fs", frame_start, 1);
    check("f1_y", pix_y, 0);
    check("underrun_sticky", underrun, 1);

    // Pause mid-line so the next pixel shown after resuming is x = 300
    tick_to(T0 + FR + 2 * HT + 299);
    check("pre_pause_x", pix_x, 299);
    enable = 1'b0;
    bad = 0;
    repeat (100) begin
      tick();
      if (de !== 1'b0 || vga_h_sync !== 1'b1 || vga_v_sync !== 1'b1) bad++;
    end
    check("pause_quiet", bad, 0);
    enable = 1'b1;
    tick();
    check("resume_de", de, 1);
    check("resume_x", pix_x, 300);
    check("resume_y", pix_y, 2);
    wait_sig(0, 1'b0, HA, "resume_fall_timeout");
    check("resume_line_end", cyc, T0 + FR + 2 * HT + 100 + HA);

    // Pause inside horizontal sync: sync goes inactive, then finishes its remaining length
    wait_sig(1, 1'b0, HT, "hs2_fall_timeout");
    t = cyc;
    check("hs2_start", cyc - (T0 + FR + 2 * HT + 100 + HA), HF);
    enable = 1'b0;
    bad = 0;
    repeat (5) begin
      tick();
      if (vga_h_sync !== 1'b1) bad++;
    end
    check("hs_pause_inactive", bad, 0);
    enable = 1'b1;
    tick();
    check("hs_resume", vga_h_sync, 0);
    wait_sig(1, 1'b1, HT, "hs2_rise_timeout");
    check("hs2_end", cyc - t, 5 + HS);

    // Reset mid-frame on line 10
    n = 0;
    while (!(de === 1'b1 && pix_y === 10'd10) && n < 4000) begin
      tick();
      n++;
    end
    check("reach_line10", pix_y, 10);
    @(negedge clk);
    rst = 1'b1;
    line_ack = 1'b0;
    #2;
    check("mid_rst_de", de, 0);
    check("mid_rst_req", line_req, 0);
    check("mid_rst_underrun", underrun, 0);
    check("mid_rst_hsync", vga_h_sync, 1);
    check("mid_rst_vsync", vga_v_sync, 1);
    check("mid_rst_pix_y", pix_y, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    age = 0;
    acked = 1'b0;
    tick();
    check("restart_req", line_req, 1);
    check("restart_req_y", line_y, 0);
    tick_to(T0);
    check("restart_de", de, 1);
    check("restart_fs", frame_start, 1);
`ifdef VGA_TEST_PATTERN_EN
    check("rgb_x0", {R, G, B}, 0);
    tick_to(T0 + 39);
    check("rgb_x39", {R, G, B}, 0);
    tick();
    check("rgb_x40", {R, G, B}, 1);
    tick_to(T0 + 79);
    check("rgb_x79", {R, G, B}, 1);
    tick();
    check("rgb_x80", {R, G, B}, 2);
    tick_to(T0 + 280);
    check("rgb_x280", {R, G, B}, 7);
    tick_to(T0 + 319);
    check("rgb_x319", {R, G, B}, 7);
    tick();
    check("rgb_blank", {R, G, B}, 0);
`endif
    tick_to(T0 + HA);
    check("restart_de_fall", de, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
